ex_stage: RTL and testbench

- Execute stage of the 5-stage pipeline. Consumer end of the decode stage's interface: takes the registered immediate, rs/rt values, destination, opcode and the 3-bit forwarding selects.
- Resolves the forwarding selects, runs the ALU and produces the EX/MEM latch.
- Runs MUL iteratively and raises a stall back to fetch/decode while the multiply is busy.

---
 rtl/ex_stage_pkg.sv | 38 +++
 rtl/ex_stage_iter_mul.sv | 56 +++++
 rtl/ex_stage.sv | 142 ++++++++++++++
 tb/tb_ex_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared opcode, forwarding and bundle definitions for the execute stage.
// Imported by ex_stage and iter_mul.
package ex_stage_pkg;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_SLT  = 6'h05;
  localparam logic [5:0] OP_MUL  = 6'h06;
  localparam logic [5:0] OP_LDW  = 6'h07;
  localparam logic [5:0] OP_SDW  = 6'h08;
  localparam logic [5:0] OP_BEQ  = 6'h09;
  localparam logic [5:0] OP_JUMP = 6'h0A;

  localparam logic [2:0] FWD_RF    = 3'd0;
  localparam logic [2:0] FWD_EXMEM = 3'd1;
  localparam logic [2:0] FWD_MEMWB = 3'd2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } ex_state_e;

  typedef struct packed {
    logic [4:0] rwd;
    logic [5:0] opcode;
    logic       br;
  } ex_ctl_t;

  localparam ex_ctl_t CTL_BUBBLE = '{rwd: 5'd0, opcode: OP_NOP, br: 1'b0};

  function automatic logic uses_imm(input logic [5:0] op);
    return (op == OP_LDW) || (op == OP_SDW);
  endfunction

endpackage

// File: rtl/ex_stage_iter_mul.sv
// Iterative shift-add multiplier: one partial product per cycle.
// done is high on the final step; res is the low product on that cycle.
module iter_mul
  import ex_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_ITER = DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] res
);

  localparam int CW = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_ITER - 1);

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [CW-1:0]     cnt;

  assign res  = acc + (mplier[0] ? mcand : '0);
  assign done = busy && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= res;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding mux, single-cycle ALU, iterative MUL
// and the EX/MEM latch. stall holds upstream while MUL is busy.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_ITER = DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [DATA_W-1:0] val_rs_in,
  input  logic [DATA_W-1:0] val_rt_in,
  input  logic [4:0]        rwd_in,
  input  logic [5:0]        opcode_in,
  input  logic [2:0]        rs_fwd,
  input  logic [2:0]        rt_fwd,
  input  logic [DATA_W-1:0] fwd1_data,
  input  logic [DATA_W-1:0] fwd2_data,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] val_rt_out,
  output logic [4:0]        rwd_out,
  output logic [5:0]        opcode_out,
  output logic              branch_taken,
  output logic              stall
);

  ex_state_e state;
  ex_ctl_t   ctl_q;
  ex_ctl_t   ctl_nxt;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_rt;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_nxt;
  logic [DATA_W-1:0] mul_res;
  logic [4:0]        mul_rwd;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;

  function automatic logic [DATA_W-1:0] fwd_pick(
    input logic [2:0]        sel,
    input logic [DATA_W-1:0] rf,
    input logic [DATA_W-1:0] f1,
    input logic [DATA_W-1:0] f2
  );
    logic [DATA_W-1:0] v;
    v = '0;
    unique case (1'b1)
      (sel == FWD_RF):    v = rf;
      (sel == FWD_EXMEM): v = f1;
      (sel == FWD_MEMWB): v = f2;
      default:            v = '0;
    endcase
    return v;
  endfunction

  assign op_a  = fwd_pick(rs_fwd, val_rs_in, fwd1_data, fwd2_data);
  assign op_rt = fwd_pick(rt_fwd, val_rt_in, fwd1_data, fwd2_data);
  assign op_b  = uses_imm(opcode_in) ? imm_in : op_rt;

  always_comb begin
    alu_nxt        = '0;
    ctl_nxt.rwd    = rwd_in;
    ctl_nxt.opcode = opcode_in;
    ctl_nxt.br     = 1'b0;
    unique case (opcode_in)
      OP_ADD:  alu_nxt = op_a + op_b;
      OP_SUB:  alu_nxt = op_a - op_b;
      OP_AND:  alu_nxt = op_a & op_b;
      OP_OR:   alu_nxt = op_a | op_b;
      OP_SLT:  alu_nxt = {{(DATA_W-1){1'b0}},
                          $signed(op_a) < $signed(op_b)};
      OP_LDW,
      OP_SDW:  alu_nxt = op_a + op_b;
      OP_BEQ:  ctl_nxt.br = (op_a == op_rt);
      OP_JUMP: alu_nxt = imm_in;
      OP_MUL:  alu_nxt = '0;
      default: ctl_nxt.rwd = 5'd0;
    endcase
  end

  assign mul_start = (state == S_IDLE) && (opcode_in == OP_MUL);

  // Gated by rst_n so upstream is never frozen while the stage is in reset.
  assign stall = rst_n && (mul_start || (mul_busy && !mul_done));

  iter_mul #(
    .DATA_W   (DATA_W),
    .MUL_ITER (MUL_ITER)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (op_a),
    .b     (op_b),
    .busy  (mul_busy),
    .done  (mul_done),
    .res   (mul_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ctl_q       <= CTL_BUBBLE;
      alu_res_out <= '0;
      val_rt_out  <= '0;
      mul_rwd     <= 5'd0;
    end else begin
      ctl_q       <= CTL_BUBBLE;
      alu_res_out <= '0;
      val_rt_out  <= '0;
      unique case (state)
        S_IDLE: begin
          if (mul_start) begin
            state   <= S_BUSY;
            mul_rwd <= rwd_in;
          end else begin
            ctl_q       <= ctl_nxt;
            alu_res_out <= alu_nxt;
            val_rt_out  <= op_rt;
          end
        end
        S_BUSY: begin
          if (mul_done) begin
            state        <= S_IDLE;
            alu_res_out  <= mul_res;
            ctl_q.rwd    <= mul_rwd;
            ctl_q.opcode <= OP_MUL;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rwd_out      = ctl_q.rwd;
  assign opcode_out   = ctl_q.opcode;
  assign branch_taken = ctl_q.br;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with a cycle-level reference model
// and a per-cycle compare process.
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam int DW = 32;
  localparam int NI = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] imm_in = '0;
  logic [DW-1:0] val_rs_in = '0;
  logic [DW-1:0] val_rt_in = '0;
  logic [4:0]    rwd_in = '0;
  logic [5:0]    opcode_in = OP_NOP;
  logic [2:0]    rs_fwd = '0;
  logic [2:0]    rt_fwd = '0;
  logic [DW-1:0] fwd1_drv = '0;
  logic [DW-1:0] fwd2_data = '0;
  logic          loop_fwd = 1'b0;
  logic [DW-1:0] fwd1_data;
  logic [DW-1:0] alu_res_out;
  logic [DW-1:0] val_rt_out;
  logic [4:0]    rwd_out;
  logic [5:0]    opcode_out;
  logic          branch_taken;
  logic          stall;

  int n_chk = 0;
  int n_fail = 0;
  int mul_seen = 0;

  assign fwd1_data = loop_fwd ? alu_res_out : fwd1_drv;

  always #5 clk = ~clk;

  ex_stage #(.DATA_W(DW), .MUL_ITER(NI)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imm_in       (imm_in),
    .val_rs_in    (val_rs_in),
    .val_rt_in    (val_rt_in),
    .rwd_in       (rwd_in),
    .opcode_in    (opcode_in),
    .rs_fwd       (rs_fwd),
    .rt_fwd       (rt_fwd),
    .fwd1_data    (fwd1_data),
    .fwd2_data    (fwd2_data),
    .alu_res_out  (alu_res_out),
    .val_rt_out   (val_rt_out),
    .rwd_out      (rwd_out),
    .opcode_out   (opcode_out),
    .branch_taken (branch_taken),
    .stall        (stall)
  );

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected EX/MEM contents after each edge.
  logic [DW-1:0] e_alu = '0;
  logic [DW-1:0] e_rt = '0;
  logic          e_rt_v = 1'b1;
  logic [4:0]    e_rwd = '0;
  logic [5:0]    e_op = OP_NOP;
  logic          e_br = 1'b0;
  int            m_left = 0;
  logic [DW-1:0] m_a = '0;
  logic [DW-1:0] m_b = '0;
  logic [4:0]    m_rd = '0;

  function automatic logic [DW-1:0] pick(input logic [2:0] s,
    input logic [DW-1:0] rf, input logic [DW-1:0] f1, input logic [DW-1:0] f2);
    if (s == 3'd0) return rf;
    if (s == 3'd1) return f1;
    if (s == 3'd2) return f2;
    return '0;
  endfunction

  task automatic bubble();
    e_alu = '0; e_rt_v = 1'b0; e_rwd = '0; e_op = OP_NOP; e_br = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [DW-1:0] a, r, b;
    if (!rst_n) begin
      e_alu = '0; e_rt = '0; e_rt_v = 1'b1; e_rwd = '0;
      e_op = OP_NOP; e_br = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      bubble();
      if (m_left == 1) begin
        e_alu = m_a * m_b; e_rwd = m_rd; e_op = OP_MUL;
      end
      m_left--;
    end else begin
      a = pick(rs_fwd, val_rs_in, fwd1_data, fwd2_data);
      r = pick(rt_fwd, val_rt_in, fwd1_data, fwd2_data);
      b = (opcode_in == OP_LDW || opcode_in == OP_SDW) ? imm_in : r;
      e_alu = '0; e_rt = r; e_rt_v = 1'b1; e_rwd = rwd_in;
      e_op = opcode_in; e_br = 1'b0;
      case (opcode_in)
        OP_ADD, OP_LDW, OP_SDW: e_alu = a + b;
        OP_SUB:  e_alu = a - b;
        OP_AND:  e_alu = a & b;
        OP_OR:   e_alu = a | b;
        OP_SLT:  e_alu = ($signed(a) < $signed(b)) ? 1 : 0;
        OP_BEQ:  e_br = (a == r);
        OP_JUMP: e_alu = imm_in;
        OP_MUL: begin
          m_left = NI; m_a = a; m_b = b; m_rd = rwd_in;
          bubble();
        end
        default: e_rwd = '0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic e_stall;
    e_stall = rst_n && ((m_left == 0 && opcode_in == OP_MUL) || m_left > 1);
    chk("cyc_alu", alu_res_out, e_alu);
    if (e_rt_v) chk("cyc_val_rt", val_rt_out, e_rt);
    chk("cyc_rwd", DW'(rwd_out), DW'(e_rwd));
    chk("cyc_opcode", DW'(opcode_out), DW'(e_op));
    chk("cyc_branch", DW'(branch_taken), DW'(e_br));
    chk("cyc_stall", DW'(stall), DW'(e_stall));
    if (opcode_out == OP_MUL) mul_seen++;
  end

  task automatic iss(input logic [5:0] op, input logic [DW-1:0] imm,
    input logic [DW-1:0] rs, input logic [DW-1:0] rt, input logic [4:0] rd,
    input logic [2:0] rsf, input logic [2:0] rtf,
    input logic [DW-1:0] f1, input logic [DW-1:0] f2);
    opcode_in = op; imm_in = imm; val_rs_in = rs; val_rt_in = rt;
    rwd_in = rd; rs_fwd = rsf; rt_fwd = rtf; fwd1_drv = f1; fwd2_data = f2;
    @(posedge clk); #1;
  endtask

  task automatic do_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [4:0] rd, input logic [DW-1:0] exp);
    int n;
    opcode_in = OP_MUL; val_rs_in = a; val_rt_in = b; rwd_in = rd;
    rs_fwd = FWD_RF; rt_fwd = FWD_RF; imm_in = '0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    chk("mul_stall_cycles", DW'(n), DW'(NI));
    @(posedge clk); #1;
    chk("mul_result", alu_res_out, exp);
    chk("mul_rwd", DW'(rwd_out), DW'(rd));
    chk("mul_opcode", DW'(opcode_out), DW'(OP_MUL));
  endtask

  initial begin
    int seen0;
    opcode_in = OP_MUL;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_alu", alu_res_out, '0);
    chk("rst_stall", DW'(stall), '0);
    opcode_in = OP_NOP;
    rst_n = 1'b1;

    iss(OP_ADD, 0, 99, 7, 5'd3, 3'd1, 3'd0, 5, 0);
    chk("add_fwd1", alu_res_out, 32'd12);
    chk("add_rwd", DW'(rwd_out), 32'd3);
    iss(OP_ADD, 0, 99, 7, 5'd3, 3'd1, 3'd2, 5, 32'hFFFF_FFFF);
    chk("add_wrap", alu_res_out, 32'd4);
    iss(OP_SDW, 32'hFFFF_FFFC, 32'h100, 0, 5'd0, 3'd0, 3'd1, 32'hAB, 0);
    chk("sdw_addr", alu_res_out, 32'hFC);
    chk("sdw_data", val_rt_out, 32'hAB);
    chk("sdw_rwd", DW'(rwd_out), 32'd0);
    iss(OP_BEQ, 0, 32'h55, 32'h55, 5'd0, 3'd0, 3'd0, 0, 0);
    chk("beq_taken", DW'(branch_taken), 32'd1);
    chk("beq_alu", alu_res_out, 32'd0);
    iss(OP_BEQ, 0, 32'h55, 32'h56, 5'd0, 3'd0, 3'd0, 0, 0);
    chk("beq_not", DW'(branch_taken), 32'd0);
    iss(OP_SLT, 0, 32'hFFFF_FFFF, 1, 5'd4, 3'd0, 3'd0, 0, 0);
    chk("slt_neg", alu_res_out, 32'd1);
    iss(OP_SUB, 0, 3, 10, 5'd4, 3'd0, 3'd0, 0, 0);
    chk("sub_neg", alu_res_out, 32'hFFFF_FFF9);
    iss(OP_AND, 0, 32'hF0F0, 32'hFF00, 5'd4, 3'd0, 3'd0, 0, 0);
    chk("and", alu_res_out, 32'hF000);
    iss(OP_OR, 0, 32'hF0F0, 32'hFF00, 5'd4, 3'd0, 3'd0, 0, 0);
    chk("or", alu_res_out, 32'hFFF0);
    iss(OP_JUMP, 32'h1234, 1, 2, 5'd0, 3'd0, 3'd0, 0, 0);
    chk("jump", alu_res_out, 32'h1234);
    iss(OP_ADD, 0, 99, 7, 5'd2, 3'd5, 3'd0, 5, 0);
    chk("fwd_reserved", alu_res_out, 32'd7);
    iss(6'h3F, 0, 1, 2, 5'd9, 3'd0, 3'd0, 0, 0);
    chk("unk_rwd", DW'(rwd_out), 32'd0);
    iss(OP_LDW, 32'd8, 32'h20, 32'h77, 5'd6, 3'd0, 3'd0, 0, 0);
    chk("ldw_addr", alu_res_out, 32'h28);
    chk("ldw_rwd", DW'(rwd_out), 32'd6);

    rst_n = 1'b0;
    #2;
    chk("midrst_alu", alu_res_out, '0);
    chk("midrst_rwd", DW'(rwd_out), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    iss(OP_NOP, 0, 0, 0, 5'd0, 3'd0, 3'd0, 0, 0);

    seen0 = mul_seen;
    do_mul(32'h10000, 32'h10003, 5'd7, 32'h0003_0000);
    loop_fwd = 1'b1;
    iss(OP_ADD, 0, 0, 1, 5'd7, 3'd1, 3'd0, 0, 0);
    chk("mul_fwd_add", alu_res_out, 32'h0003_0001);
    loop_fwd = 1'b0;
    do_mul(3, 4, 5'd8, 32'd12);
    do_mul(5, 6, 5'd9, 32'd30);
    iss(OP_NOP, 0, 0, 0, 5'd0, 3'd0, 3'd0, 0, 0);
    repeat (3) @(posedge clk);
    chk("mul_count", DW'(mul_seen - seen0), 32'd3);

    opcode_in = OP_MUL; val_rs_in = 7; val_rt_in = 9; rwd_in = 5'd5;
    repeat (3) @(posedge clk);
    #1;
    seen0 = mul_seen;
    rst_n = 1'b0;
    opcode_in = OP_NOP;
    #2;
    chk("busyrst_stall", DW'(stall), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("busyrst_no_result", DW'(mul_seen - seen0), 32'd0);
    chk("busyrst_stall_idle", DW'(stall), '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
